svm_alpha_sequencer: RTL and testbench



---
 rtl/svm_pkg.sv | 28 ++
 rtl/svm_alpha_rom.sv | 30 +++
 rtl/svm_alpha_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_svm_alpha_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared definitions for the SVM alpha sequencer: FSM state encoding, result
// width helper and the default alpha ROM image.
// Entry i of ALPHA_ROM_INIT is bits [i*ROM_NBITS +: ROM_NBITS]; V alphas come
// first (entries 0..3), then A alphas (entries 4..6).
package svm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    V_RUN  = 3'd1,
    V_WAIT = 3'd2,
    A_RUN  = 3'd3,
    A_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Width of one matmul2 accumulated dot product.
  function automatic int rwidth(input int nbits, input int log_f_width,
                                input int log_sup_width);
    return nbits * (nbits + log_f_width) + log_sup_width;
  endfunction

  localparam int ROM_NBITS = 16;
  localparam int ROM_DEPTH = 7;

  // Default image: every alpha is +1.
  localparam logic [ROM_DEPTH*ROM_NBITS-1:0] ALPHA_ROM_INIT = {ROM_DEPTH{16'h0001}};

endpackage

// File: rtl/svm_alpha_rom.sv
// Alpha coefficient ROM, NBITS signed entries, contents fixed by INIT.
// Latency: 1 cycle, registered read data. No backpressure: a new address every cycle.
// Ports: i_clk, i_rst (async, active-high), i_addr (entry index), o_dat (signed entry).
module svm_alpha_rom #(
  parameter int NBITS  = 16,
  parameter int DEPTH  = 7,
  parameter int AWIDTH = 3,
  parameter logic [DEPTH*NBITS-1:0] INIT = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [AWIDTH-1:0]       i_addr,
  output logic signed [NBITS-1:0] o_dat
);

  logic signed [NBITS-1:0] r_dat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dat <= '0;
    end else if (int'(i_addr) < DEPTH) begin
      r_dat <= INIT[int'(i_addr)*NBITS +: NBITS];
    end else begin
      r_dat <= '0;
    end
  end

  assign o_dat = r_dat;

endmodule

// File: rtl/svm_alpha_sequencer.sv
// Issues V then A alpha streams to matmul2, collects both results, emits scores + fused label.
// Latency: done at VSUP_WIDTH+ASUP_WIDTH+5 cycles after start when matmul2 answers promptly.
// Backpressure: none on the alpha stream; late matmul2 completions stretch the wait states.
// Ports: clk/rst (async active-high); start/ready/done handshake with classify control;
//   v_alpha/a_alpha/comp_sidx_delay/*_alpha_valid towards matmul2; matmul2_result and
//   matmul2_*_valid back from it; v_score/a_score/fused_score/label held results.
// Build option: define SVM_BIAS_EN to add V_BIAS / A_BIAS to the captured scores.
module svm_alpha_sequencer
  import svm_pkg::*;
#(
  parameter int NBITS         = 16,
  parameter int LOG_F_WIDTH   = 10,
  parameter int VSUP_WIDTH    = 4,
  parameter int ASUP_WIDTH    = 3,
  parameter int SUP_WIDTH     = 4,
  parameter int LOG_SUP_WIDTH = 2,
  parameter logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH)-1:0] V_BIAS = '0,
  parameter logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH)-1:0] A_BIAS = '0,
  parameter logic [(VSUP_WIDTH+ASUP_WIDTH)*NBITS-1:0] ALPHA_ROM = ALPHA_ROM_INIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  output logic                    done,
  output logic signed [NBITS-1:0] v_alpha,
  output logic signed [NBITS-1:0] a_alpha,
  output logic [LOG_SUP_WIDTH-1:0] comp_sidx_delay,
  output logic                    v_alpha_valid,
  output logic                    a_alpha_valid,
  input  logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH)-1:0] matmul2_result,
  input  logic                    matmul2_v_valid,
  input  logic                    matmul2_a_valid,
  output logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH):0]   v_score,
  output logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH):0]   a_score,
  output logic signed [rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH)+1:0] fused_score,
  output logic                    label
);

  localparam int RWIDTH = rwidth(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH);
  localparam int DEPTH  = VSUP_WIDTH + ASUP_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = $clog2(SUP_WIDTH);

`ifdef SVM_BIAS_EN
  localparam logic BIAS_EN = 1'b1;
`else
  localparam logic BIAS_EN = 1'b0;
`endif

  // Biases fold to zero when the feature is off, so both builds share one datapath.
  localparam logic signed [RWIDTH-1:0] W_V_BIAS = BIAS_EN ? V_BIAS : '0;
  localparam logic signed [RWIDTH-1:0] W_A_BIAS = BIAS_EN ? A_BIAS : '0;

  state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_last_idx;
  logic                    w_last;
  logic                    w_v_issue, w_a_issue;
  logic                    w_v_capture, w_a_capture;
  logic [AW-1:0]           w_rom_addr;
  logic signed [NBITS-1:0] w_rom_dat;

  logic                    r_v_vld, r_a_vld;
  logic [IDX_W-1:0]        r_sidx;

  logic signed [RWIDTH:0]   w_v_capt, w_a_capt;
  logic signed [RWIDTH+1:0] w_fused_nxt;
  logic signed [RWIDTH:0]   r_v_score, r_a_score;
  logic signed [RWIDTH+1:0] r_fused;
  logic                     r_label;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last_idx = (r_state == A_RUN) ? IDX_W'(ASUP_WIDTH - 1) : IDX_W'(VSUP_WIDTH - 1);
  assign w_last     = (r_idx == w_last_idx);

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start)           w_state_nxt = V_RUN;
      V_RUN:   if (w_last)          w_state_nxt = V_WAIT;
      V_WAIT:  if (matmul2_v_valid) w_state_nxt = A_RUN;
      A_RUN:   if (w_last)          w_state_nxt = A_WAIT;
      A_WAIT:  if (matmul2_a_valid) w_state_nxt = DONE;
      DONE:                         w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    w_v_issue   = 1'b0;
    w_a_issue   = 1'b0;
    w_v_capture = 1'b0;
    w_a_capture = 1'b0;
    w_rom_addr  = '0;
    unique case (r_state)
      IDLE:   ready = 1'b1;
      V_RUN: begin
        w_v_issue  = 1'b1;
        w_rom_addr = AW'(r_idx);
      end
      V_WAIT: w_v_capture = matmul2_v_valid;
      A_RUN: begin
        w_a_issue  = 1'b1;
        w_rom_addr = AW'(VSUP_WIDTH) + AW'(r_idx);
      end
      A_WAIT: w_a_capture = matmul2_a_valid;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  // Index counter: runs only in the RUN states and is zero everywhere else,
  // so each modality (and each new start) begins at support vector 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_v_issue || w_a_issue) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end else begin
      r_idx <= '0;
    end
  end

  svm_alpha_rom #(
    .NBITS  (NBITS),
    .DEPTH  (DEPTH),
    .AWIDTH (AW),
    .INIT   (ALPHA_ROM)
  ) u_rom (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_addr (w_rom_addr),
    .o_dat  (w_rom_dat)
  );

  // Issue flags and index delayed one cycle so they line up with ROM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_vld <= 1'b0;
      r_a_vld <= 1'b0;
      r_sidx  <= '0;
    end else begin
      r_v_vld <= w_v_issue;
      r_a_vld <= w_a_issue;
      r_sidx  <= (w_v_issue || w_a_issue) ? r_idx : '0;
    end
  end

  assign v_alpha_valid   = r_v_vld;
  assign a_alpha_valid   = r_a_vld;
  assign comp_sidx_delay = LOG_SUP_WIDTH'(r_sidx);
  // ROM data persists after a run; the inactive modality must read as zero.
  assign v_alpha         = r_v_vld ? w_rom_dat : '0;
  assign a_alpha         = r_a_vld ? w_rom_dat : '0;

  // ---------------- score capture ----------------
  assign w_v_capt = {matmul2_result[RWIDTH-1], matmul2_result} + {W_V_BIAS[RWIDTH-1], W_V_BIAS};
  assign w_a_capt = {matmul2_result[RWIDTH-1], matmul2_result} + {W_A_BIAS[RWIDTH-1], W_A_BIAS};
  // Fused uses the A score being captured this cycle, not the stale register.
  assign w_fused_nxt = {r_v_score[RWIDTH], r_v_score} + {w_a_capt[RWIDTH], w_a_capt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_score <= '0;
      r_a_score <= '0;
      r_fused   <= '0;
      r_label   <= 1'b0;
    end else begin
      if (w_v_capture) begin
        r_v_score <= w_v_capt;
      end
      if (w_a_capture) begin
        r_a_score <= w_a_capt;
        r_fused   <= w_fused_nxt;
        r_label   <= ~w_fused_nxt[RWIDTH+1];
      end
    end
  end

  assign v_score     = r_v_score;
  assign a_score     = r_a_score;
  assign fused_score = r_fused;
  assign label       = r_label;

endmodule

// File: tb/tb_svm_alpha_sequencer.sv
// Directed bench for svm_alpha_sequencer: two instances share stimulus, one with the
// default +1 ROM (and biases -20/+3), one with V alphas -1; a behavioural matmul2
// accumulates the issued alphas against matmul1 = {2,3,4,5}.
module tb_svm_alpha_sequencer;

  localparam int NB = 16;
  localparam int RW = svm_pkg::rwidth(16, 10, 2);

  localparam logic [7*16-1:0] NEG_ROM =
    {16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

`ifdef SVM_BIAS_EN
  localparam int EV0 = -6;
  localparam int EA0 = 12;
`else
  localparam int EV0 = 14;
  localparam int EA0 = 9;
`endif
  localparam int EV1 = -14;
  localparam int EA1 = 9;

  logic clk = 1'b0;
  logic rst, start, mv, ma, stray_a;
  logic signed [RW-1:0] res0, res1;

  logic ready0, done0, v_valid0, a_valid0, label0;
  logic ready1, done1, v_valid1, a_valid1, label1;
  logic signed [NB-1:0] v_alpha0, a_alpha0, v_alpha1, a_alpha1;
  logic [1:0] sidx0, sidx1;
  logic signed [RW:0]   v_score0, a_score0, v_score1, a_score1;
  logic signed [RW+1:0] fused0, fused1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  svm_alpha_sequencer #(.V_BIAS(-20), .A_BIAS(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .ready(ready0), .done(done0),
    .v_alpha(v_alpha0), .a_alpha(a_alpha0), .comp_sidx_delay(sidx0),
    .v_alpha_valid(v_valid0), .a_alpha_valid(a_valid0),
    .matmul2_result(res0), .matmul2_v_valid(mv), .matmul2_a_valid(ma),
    .v_score(v_score0), .a_score(a_score0), .fused_score(fused0), .label(label0)
  );

  svm_alpha_sequencer #(.ALPHA_ROM(NEG_ROM)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .ready(ready1), .done(done1),
    .v_alpha(v_alpha1), .a_alpha(a_alpha1), .comp_sidx_delay(sidx1),
    .v_alpha_valid(v_valid1), .a_alpha_valid(a_valid1),
    .matmul2_result(res1), .matmul2_v_valid(mv), .matmul2_a_valid(ma),
    .v_score(v_score1), .a_score(a_score1), .fused_score(fused1), .label(label1)
  );

  // ---------------- matmul2 model ----------------
  int     m1 [4] = '{2, 3, 4, 5};
  longint acc0, acc1;
  int     v_cnt, a_cnt;
  int     v_delay   = 0;
  int     stray_cyc = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc0 <= 0; acc1 <= 0; v_cnt <= 0; a_cnt <= 0;
    end else begin
      if (v_valid0 || a_valid0)
        acc0 <= (sidx0 == 2'd0 ? 64'sd0 : acc0) +
                (longint'(v_alpha0) + longint'(a_alpha0)) * longint'(m1[sidx0]);
      if (v_valid1 || a_valid1)
        acc1 <= (sidx1 == 2'd0 ? 64'sd0 : acc1) +
                (longint'(v_alpha1) + longint'(a_alpha1)) * longint'(m1[sidx1]);
      if (v_valid0 && sidx0 == 2'd3) v_cnt <= v_delay + 1;
      else if (v_cnt > 0)            v_cnt <= v_cnt - 1;
      if (a_valid0 && sidx0 == 2'd2) a_cnt <= 1;
      else if (a_cnt > 0)            a_cnt <= a_cnt - 1;
    end
  end

  assign res0 = {{(RW-64){acc0[63]}}, acc0};
  assign res1 = {{(RW-64){acc1[63]}}, acc1};
  assign mv   = (v_cnt == 1);
  assign ma   = (a_cnt == 1) || stray_a;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [RW+1:0] got,
                       input logic signed [RW+1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Per-run observation statistics.
  int   n_v, n_a, first_v, first_a, n_done, done_c0, done_c1;
  int   sidx_err, alpha_err, zero_err, adj_err, sync_err;
  logic prev_v, prev_a;
  logic rdy [64];

  // Called at a negedge in relative cycle 0; start is driven for start_cycles cycles.
  task automatic watch(input int ncyc, input int start_cycles);
    n_v = 0; n_a = 0; first_v = -1; first_a = -1; n_done = 0; done_c0 = -1; done_c1 = -1;
    sidx_err = 0; alpha_err = 0; zero_err = 0; adj_err = 0; sync_err = 0;
    prev_v = 1'b0; prev_a = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (v_valid0) begin
        if (n_v == 0) first_v = c;
        if (int'(sidx0) != n_v % 4) sidx_err++;
        if (v_alpha0 != 16'sd1 || v_alpha1 != -16'sd1) alpha_err++;
        n_v++;
      end else if (v_alpha0 != 0 || v_alpha1 != 0) zero_err++;
      if (a_valid0) begin
        if (n_a == 0) first_a = c;
        if (int'(sidx0) != n_a % 3) sidx_err++;
        if (a_alpha0 != 16'sd1 || a_alpha1 != 16'sd1) alpha_err++;
        n_a++;
      end else if (a_alpha0 != 0 || a_alpha1 != 0) zero_err++;
      if ((v_valid0 && prev_a) || (a_valid0 && prev_v)) adj_err++;
      prev_v = v_valid0;
      prev_a = a_valid0;
      if (done0) begin
        if (n_done == 0) done_c0 = c;
        else if (n_done == 1) done_c1 = c;
        n_done++;
      end
      if (done0 != done1 || v_valid0 != v_valid1) sync_err++;
      rdy[c] = ready0;
      start   = (c < start_cycles);
      stray_a = (c == stray_cyc);
      @(negedge clk);
    end
    start   = 1'b0;
    stray_a = 1'b0;
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_v_score0"}, v_score0, EV0);
    check({tag, "_a_score0"}, a_score0, EA0);
    check({tag, "_fused0"},   fused0,   EV0 + EA0);
    check({tag, "_label0"},   label0,   (EV0 + EA0 >= 0) ? 1 : 0);
    check({tag, "_v_score1"}, v_score1, EV1);
    check({tag, "_a_score1"}, a_score1, EA1);
    check({tag, "_fused1"},   fused1,   EV1 + EA1);
    check({tag, "_label1"},   label1,   (EV1 + EA1 >= 0) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stray_a = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", ready0, 1);
    check("rst_done", done0, 0);
    check("rst_v_valid", v_valid0, 0);
    check("rst_a_valid", a_valid0, 0);
    check("rst_sidx", sidx0, 0);
    check("rst_v_score", v_score0, 0);
    check("rst_label", label0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run (DUT0) and negative-alpha run (DUT1) in parallel
    watch(20, 1);
    check("basic_first_v", first_v, 2);
    check("basic_n_v", n_v, 4);
    check("basic_first_a", first_a, 8);
    check("basic_n_a", n_a, 3);
    check("basic_sidx_err", sidx_err, 0);
    check("basic_alpha_err", alpha_err, 0);
    check("basic_zero_err", zero_err, 0);
    check("basic_done_cyc", done_c0, 12);
    check("basic_n_done", n_done, 1);
    check("basic_ready_at_done", rdy[12], 0);
    check("basic_ready_after", rdy[13], 1);
    check("basic_sync", sync_err, 0);
    check_scores("basic");

    // Busy start: start held for 20 cycles
    watch(34, 20);
    check("busy_n_done", n_done, 2);
    check("busy_done0", done_c0, 12);
    check("busy_done1", done_c1, 25);
    check("busy_n_v", n_v, 8);
    check("busy_adjacent", adj_err, 0);
    check_scores("busy");

    // Mid-run reset at cycle 4
    watch(4, 1);
    check("mid_v_valid_before", v_valid0, 1);
    rst = 1'b1;
    #1;
    check("mid_v_valid", v_valid0, 0);
    check("mid_a_valid", a_valid0, 0);
    check("mid_v_alpha", v_alpha0, 0);
    check("mid_ready", ready0, 1);
    check("mid_v_score", v_score0, 0);
    check("mid_a_score", a_score0, 0);
    check("mid_fused", fused0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    watch(20, 1);
    check("post_rst_done", done_c0, 12);
    check("post_rst_n_v", n_v, 4);
    check_scores("post_rst");

    // Late V completion plus stray A completion during V_WAIT
    v_delay   = 5;
    stray_cyc = 8;
    watch(25, 1);
    check("late_done_cyc", done_c0, 17);
    check("late_n_done", n_done, 1);
    check("late_first_a", first_a, 13);
    check_scores("late");
    v_delay   = 0;
    stray_cyc = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
